// File: rtl/bin_to_bcd_scan.sv
// 14-bit binary to 4-digit BCD (sequential double-dabble) with a multiplexed
// digit scan that feeds a BCD-to-seven-segment decoder; 4'hF is the blank code.

module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin_to_bcd_scan #(
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [3:0]  outBCD,
  output logic [3:0]  an
);

  localparam int          NDIG   = 4;
  localparam logic [19:0] PRE_TC = 20'(SCAN_DIV - 1);
  localparam logic [3:0]  BLANK  = 4'hF;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t                     state, state_n;
  logic [13:0]                sh, sh_n;
  logic [NDIG-1:0][3:0]       scr, adj, scr_n;
  logic [29:0]                shifted;
  logic [3:0]                 iter;
  logic                       ovf;
  logic [NDIG-1:0][3:0]       dig, shown;
  logic [19:0]                pre;
  logic [1:0]                 idx;

  // add-3 correction on every scratch nibble, ahead of the shift
  for (genvar g = 0; g < NDIG; g++) begin : g_dab
    bcd_add3 u_add3 (.din(scr[g]), .dout(adj[g]));
  end

  assign shifted = {adj, sh} << 1;
  assign scr_n   = shifted[29:14];
  assign sh_n    = shifted[13:0];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (load) state_n = CONV;
      CONV:    if (iter == 4'd13) state_n = UPDATE;
      UPDATE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh   <= '0;
      scr  <= '0;
      iter <= '0;
      ovf  <= 1'b0;
      dig  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load) begin
          sh   <= value;
          scr  <= '0;
          iter <= '0;
          ovf  <= (value > 14'd9999);
        end
        CONV: begin
          scr  <= scr_n;
          sh   <= sh_n;
          iter <= iter + 4'd1;
        end
        UPDATE: begin
          dig  <= ovf ? {NDIG{BLANK}} : scr;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // overflow digits are already 4'hF, so they pass through untouched here
  always_comb begin
    shown = dig;
    if (LZ_BLANK) begin
      if (dig[3] == 4'd0)                                      shown[3] = BLANK;
      if (dig[3] == 4'd0 && dig[2] == 4'd0)                    shown[2] = BLANK;
      if (dig[3] == 4'd0 && dig[2] == 4'd0 && dig[1] == 4'd0)  shown[1] = BLANK;
    end
  end

  // scan runs free of the FSM; outputs re-evaluated every cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre    <= '0;
      idx    <= '0;
      an     <= 4'b1110;
      outBCD <= 4'h0;
    end else begin
      if (pre == PRE_TC) begin
        pre <= '0;
        idx <= idx + 2'd1;
      end else begin
        pre <= pre + 20'd1;
      end
      an     <= ~(4'b0001 << idx);
      outBCD <= shown[idx];
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_scan.sv
// Directed bench for bin_to_bcd_scan: conversion timing, scan order, blanking,
// overflow, load-while-busy and reset mid-conversion.

module tb_bin_to_bcd_scan;

  localparam int SDIV = 4;

  logic        clk, rst, load;
  logic [13:0] value;
  logic        busy1, done1, busy0, done0;
  logic [3:0]  bcd1, an1, bcd0, an0;

  int n_chk  = 0;
  int n_fail = 0;

  bin_to_bcd_scan #(.SCAN_DIV(SDIV), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy1), .done(done1), .outBCD(bcd1), .an(an1)
  );

  bin_to_bcd_scan #(.SCAN_DIV(SDIV), .LZ_BLANK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy0), .done(done0), .outBCD(bcd0), .an(an0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] get_an(input bit sel);
    return sel ? an0 : an1;
  endfunction

  function automatic logic [3:0] get_bcd(input bit sel);
    return sel ? bcd0 : bcd1;
  endfunction

  // expected digits packed {d3,d2,d1,d0}; checks value and dwell per index
  task automatic read_digits(input string tag, input bit sel, input logic [15:0] exp);
    logic [3:0] pat [4];
    logic [3:0] prv, cur;
    int budget, dwell;
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
    prv = get_an(sel);
    @(negedge clk);
    cur = get_an(sel);
    for (int i = 0; i < 4; i++) begin
      budget = 0;
      while (!(cur == pat[i] && prv != pat[i]) && budget < 40) begin
        prv = cur;
        @(negedge clk);
        cur = get_an(sel);
        budget++;
      end
      chk($sformatf("%s idx%0d reached", tag, i), int'(budget < 40), 1);
      if (budget >= 40) return;
      chk($sformatf("%s d%0d", tag, i), int'(get_bcd(sel)), int'(exp[i*4 +: 4]));
      dwell = 0;
      while (cur == pat[i] && dwell < 40) begin
        dwell++;
        prv = cur;
        @(negedge clk);
        cur = get_an(sel);
      end
      chk($sformatf("%s dwell%0d", tag, i), dwell, SDIV);
    end
  endtask

  // mid >= 0 pulses a load of 42 that many cycles into the conversion
  task automatic convert(input logic [13:0] v, input int mid);
    int cnt, early;
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    cnt   = 0;
    early = 0;
    while (busy1 && cnt < 40) begin
      if (done1) early++;
      if (cnt == mid) begin
        value = 14'd42;
        load  = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
      cnt++;
    end
    chk($sformatf("busy_len %0d", v), cnt, 15);
    chk($sformatf("done_early %0d", v), early, 0);
    chk($sformatf("done_pulse %0d", v), int'(done1), 1);
    @(negedge clk);
    chk($sformatf("done_1cyc %0d", v), int'(done1), 0);
  endtask

  initial begin
    int dn, bz;
    rst   = 1'b0;
    load  = 1'b0;
    value = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst an",     int'(an1),   4'b1110);
    chk("rst bcd",    int'(bcd1),  0);
    chk("rst busy",   int'(busy1), 0);
    chk("rst done",   int'(done1), 0);
    chk("rst an lz0", int'(an0),   4'b1110);

    convert(14'd1234, -1);
    read_digits("v1234", 1'b0, 16'h1234);
    read_digits("v1234 lz0", 1'b1, 16'h1234);

    convert(14'd7, -1);
    read_digits("v7", 1'b0, 16'hFFF7);
    read_digits("v7 lz0", 1'b1, 16'h0007);

    convert(14'd0, -1);
    read_digits("v0", 1'b0, 16'hFFF0);

    convert(14'd1005, -1);
    read_digits("v1005", 1'b0, 16'h1005);

    convert(14'd9999, -1);
    read_digits("v9999", 1'b0, 16'h9999);

    convert(14'd12000, -1);
    read_digits("v12000", 1'b0, 16'hFFFF);

    convert(14'd10000, -1);
    read_digits("v10000", 1'b0, 16'hFFFF);
    read_digits("v10000 lz0", 1'b1, 16'hFFFF);

    convert(14'd555, 3);
    dn = 0;
    bz = 0;
    repeat (20) begin
      @(negedge clk);
      if (done1) dn++;
      if (busy1) bz++;
    end
    chk("ldbusy no_done", dn, 0);
    chk("ldbusy no_busy", bz, 0);
    read_digits("v555", 1'b0, 16'hF555);

    convert(14'd1234, -1);
    value = 14'd9999;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst busy", int'(busy1), 0);
    chk("midrst bcd",  int'(bcd1),  0);
    chk("midrst an",   int'(an1),   4'b1110);
    rst = 1'b1;
    dn = 0;
    bz = 0;
    repeat (30) begin
      @(negedge clk);
      if (done1) dn++;
      if (busy1) bz++;
    end
    chk("midrst no_done", dn, 0);
    chk("midrst no_busy", bz, 0);
    read_digits("midrst", 1'b0, 16'hFFF0);
    read_digits("midrst lz0", 1'b1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_scan.md
Name: bin_to_bcd_scan

Overview:
- Upstream feeder for the BCD-to-seven-segment decoder on the 4-digit display path.
- Converts a 14-bit binary value (0..9999) to four BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto one 4-bit BCD bus, with matching active-low digit enables.
- outBCD connects directly to the decoder's inBCD. Code 4'hF is the blank code; the decoder's default case drives it to all segments off.

Parameters:
SCAN_DIV, 50000, clocks each digit is displayed before advancing (legal range 2..2^20-1).
LZ_BLANK, 1, 1 = blank leading zeros on digits 3..1; 0 = show all digits.

Ports:
clk      input   1   system clock; all logic is on the rising edge.
rst      input   1   synchronous, active-low reset.
value    input   14  binary value to display; sampled only when load is accepted.
load     input   1   start a conversion; accepted only in IDLE.
busy     output  1   high while a conversion is in progress.
done     output  1   one-cycle pulse when new digits reach the display registers.
outBCD   output  4   BCD digit currently scanned; goes to the decoder's inBCD.
an       output  4   digit enables, active-low; an[0] = units, an[3] = thousands.

Behaviour:
- Reset: when rst==0 at a clk edge, all of the following are set:
  - FSM goes to IDLE; busy=0, done=0.
  - Display digits d3..d0 = 0 and the overflow flag is cleared.
  - Prescaler = 0, digit index = 0, an=4'b1110, outBCD=4'h0.
  - Any conversion in progress is aborted and its result is never written.
- FSM states: IDLE, CONV, UPDATE.
  - IDLE: if load==1 at edge k:
    - Capture value into the shift register and clear the BCD scratch.
    - Set ovf = (value > 9999); iteration counter = 0; busy=1; go to CONV.
  - CONV: one double-dabble iteration per clock.
    - First, every scratch nibble >= 5 gets +3.
    - Then {scratch, shift} is shifted left by 1.
    - After 14 iterations (edges k+1..k+14), go to UPDATE.
  - UPDATE, at edge k+15:
    - Copy scratch to d3..d0; if ovf, load all four digits with 4'hF instead.
    - busy=0, done=1 for exactly one cycle; go to IDLE.
  - busy is therefore high for exactly 15 cycles. load while busy is ignored and not queued.
  - load in the cycle where done is high (FSM already in IDLE) is accepted normally.
  - The display keeps showing the old digits until the UPDATE edge.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - At terminal count: prescaler wraps to 0 and the digit index increments mod 4 (3 -> 0).
  - an and outBCD are registered and change on the same edge; exactly one an bit is low at any time.
  - an pattern by index: 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
  - outBCD for index i is d_i after blanking. It is recomputed every cycle, so a d update shows on the next edge without waiting for a scan step.
- Leading-zero blanking (LZ_BLANK=1) replaces the digit with 4'hF as follows:
  - d3 is blanked if d3==0.
  - d2 is blanked if d3==0 and d2==0.
  - d1 is blanked if d3, d2 and d1 are all 0.
  - d0 is never blanked.
  - Inner zeros are never blanked.
- Overflow: any value 10000..16383 blanks all four digits, including d0.
- Width rules: scratch nibbles are 4 bits. The add-3 happens before the shift, so no nibble exceeds 9 after a shift. The prescaler is 20 bits.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> an=1110, outBCD=0, busy=0, done=0 on the first cycle after release.
- Basic conversion: SCAN_DIV=4, value=1234, load pulsed at edge k ->
  - busy high for exactly 15 cycles; done high only in the cycle after edge k+15.
  - Scan then shows outBCD 4,3,2,1 with an 1110,1101,1011,0111, each for 4 clocks, then wraps.
- Blanking with LZ_BLANK=1:
  - value=7 -> indices 0..3 show 7,F,F,F.
  - value=0 -> 0,F,F,F.
  - value=1005 -> 5,0,0,1 (inner zeros shown).
  - With LZ_BLANK=0, value=7 -> 7,0,0,0.
- Range limits: value=9999 -> 9,9,9,9; value=12000 -> F,F,F,F on all indices; value=10000 -> F,F,F,F.
- Load while busy: load value=42 during busy -> ignored; no second done pulse; the first result is displayed.
- Reset mid-conversion: drive rst=0 at edge k+7 -> busy=0 and all displayed digits 0 after that edge; no done pulse follows.
